// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-compatible PIC read/write front end.
//   pic_state_e   : initialisation sequence state (ICW1..ICW4, then READY)
//   *_BIT         : bit positions inside ICW1/OCW bytes used by the decoder
//   FLAG_*        : positions inside the internal 7-bit register-written vector
package pic_pkg;

  typedef enum logic [2:0] {
    WAIT_ICW1 = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_state_e;

  localparam int ICW1_ID_BIT   = 4;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW1_IC4_BIT  = 0;
  localparam int OCW3_ID_BIT   = 3;

  localparam int FLAG_ICW1 = 0;
  localparam int FLAG_ICW2 = 1;
  localparam int FLAG_ICW3 = 2;
  localparam int FLAG_ICW4 = 3;
  localparam int FLAG_OCW1 = 4;
  localparam int FLAG_OCW2 = 5;
  localparam int FLAG_OCW3 = 6;
  localparam int NUM_FLAGS = 7;

endpackage

// File: rtl/pic_write_strobe.sv
// Write strobe qualification for the PIC bus interface.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   chip_select_bar  : chip select, active low
//   read_bar         : read strobe, active low
//   write_bar        : write strobe, active low
//   wr_active        : combinational "a write is being presented this cycle"
//   wr_q             : wr_active registered
//   write_done       : high in the cycle whose rising edge closes a write
//                      (previous cycle was writing, this one is not)
module pic_write_strobe (
  input  logic clk,
  input  logic reset,
  input  logic chip_select_bar,
  input  logic read_bar,
  input  logic write_bar,
  output logic wr_active,
  output logic wr_q,
  output logic write_done
);

  // Both strobes low is a bus conflict, not a write.
  assign wr_active = ~chip_select_bar & ~write_bar & read_bar;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_active;
    end
  end

  // Covers both write_bar rising and chip select dropping first.
  assign write_done = wr_q & ~wr_active;

endmodule

// File: rtl/pic_read_write_logic.sv
// Read/write control front end of the 8259A-compatible PIC.
// Captures CPU write bytes onto internal_bus and, when each write ends,
// decodes it as ICW1-ICW4 / OCW1-OCW3, pulsing one flag for one clk cycle.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   data_bus_buffer            : CPU data bus (sampled only, never driven)
//   internal_bus               : last captured write byte
//   chip_select_bar, read_bar, write_bar, A0 : CPU bus controls
//   ICW_n_flag / OCW_n_flag    : one-cycle "register written" pulses
//   debug_state                : current initialisation state
//
// Handshake: a write is presented while chip_select_bar=0, write_bar=0 and
// read_bar=1; the byte and A0 are re-captured on every such edge (last one
// wins). The first edge that sees the write gone decodes the captured pair;
// the resulting flag is high during the following cycle only.
module pic_read_write_logic
  import pic_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [DATA_WIDTH-1:0] data_bus_buffer,
  output logic [DATA_WIDTH-1:0] internal_bus,
  input  logic                  chip_select_bar,
  input  logic                  read_bar,
  input  logic                  write_bar,
  input  logic                  A0,
  output logic                  ICW_1_flag,
  output logic                  ICW_2_flag,
  output logic                  ICW_3_flag,
  output logic                  ICW_4_flag,
  output logic                  OCW_1_flag,
  output logic                  OCW_2_flag,
  output logic                  OCW_3_flag,
  output pic_state_e            debug_state
);

  logic wr_active;
  logic wr_q;
  logic write_done;

  pic_write_strobe u_strobe (
    .clk             (clk),
    .reset           (reset),
    .chip_select_bar (chip_select_bar),
    .read_bar        (read_bar),
    .write_bar       (write_bar),
    .wr_active       (wr_active),
    .wr_q            (wr_q),
    .write_done      (write_done)
  );

  pic_state_e             state;
  pic_state_e             next_state;
  logic                   a0_q;
  logic                   sngl;
  logic                   ic4;
  logic [NUM_FLAGS-1:0]   flags;
  logic [NUM_FLAGS-1:0]   next_flags;
  logic                   icw1_hit;

  // Decode and next state. Only evaluated as meaningful when write_done is
  // high; at that edge wr_active is low, so internal_bus/a0_q already hold
  // the final captured write.
  always_comb begin
    next_state = state;
    next_flags = '0;
    icw1_hit   = 1'b0;
    if (write_done) begin
      if (!a0_q && internal_bus[ICW1_ID_BIT]) begin
        // ICW1 restarts initialisation from any state.
        icw1_hit              = 1'b1;
        next_flags[FLAG_ICW1] = 1'b1;
        next_state            = WAIT_ICW2;
      end else begin
        case (state)
          WAIT_ICW2: begin
            if (a0_q) begin
              next_flags[FLAG_ICW2] = 1'b1;
              if (!sngl)    next_state = WAIT_ICW3;
              else if (ic4) next_state = WAIT_ICW4;
              else          next_state = READY;
            end
          end
          WAIT_ICW3: begin
            if (a0_q) begin
              next_flags[FLAG_ICW3] = 1'b1;
              next_state            = ic4 ? WAIT_ICW4 : READY;
            end
          end
          WAIT_ICW4: begin
            if (a0_q) begin
              next_flags[FLAG_ICW4] = 1'b1;
              next_state            = READY;
            end
          end
          READY: begin
            if (a0_q)                           next_flags[FLAG_OCW1] = 1'b1;
            else if (internal_bus[OCW3_ID_BIT]) next_flags[FLAG_OCW3] = 1'b1;
            else                                next_flags[FLAG_OCW2] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_ICW1;
      flags        <= '0;
      internal_bus <= '0;
      a0_q         <= 1'b0;
      sngl         <= 1'b0;
      ic4          <= 1'b0;
    end else begin
      state <= next_state;
      flags <= next_flags;
      if (wr_active) begin
        internal_bus <= data_bus_buffer;
        a0_q         <= A0;
      end
      if (icw1_hit) begin
        sngl <= internal_bus[ICW1_SNGL_BIT];
        ic4  <= internal_bus[ICW1_IC4_BIT];
      end
    end
  end

  assign ICW_1_flag  = flags[FLAG_ICW1];
  assign ICW_2_flag  = flags[FLAG_ICW2];
  assign ICW_3_flag  = flags[FLAG_ICW3];
  assign ICW_4_flag  = flags[FLAG_ICW4];
  assign OCW_1_flag  = flags[FLAG_OCW1];
  assign OCW_2_flag  = flags[FLAG_OCW2];
  assign OCW_3_flag  = flags[FLAG_OCW3];
  assign debug_state = state;

endmodule

// File: tb/tb_pic_read_write_logic.sv
module tb_pic_read_write_logic;

  // Flag vector layout in this bench: {OCW3,OCW2,OCW1,ICW4,ICW3,ICW2,ICW1}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_ICW1 = 7'b0000001;
  localparam logic [6:0] F_ICW2 = 7'b0000010;
  localparam logic [6:0] F_ICW3 = 7'b0000100;
  localparam logic [6:0] F_ICW4 = 7'b0001000;
  localparam logic [6:0] F_OCW1 = 7'b0010000;
  localparam logic [6:0] F_OCW2 = 7'b0100000;
  localparam logic [6:0] F_OCW3 = 7'b1000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       chip_select_bar = 1'b1;
  logic       read_bar = 1'b1;
  logic       write_bar = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] drv_data = 8'h00;
  wire  [7:0] data_bus_buffer;
  assign data_bus_buffer = drv_data;

  logic [7:0] internal_bus;
  logic icw1_f, icw2_f, icw3_f, icw4_f, ocw1_f, ocw2_f, ocw3_f;
  pic_pkg::pic_state_e debug_state;

  pic_read_write_logic #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_bus_buffer (data_bus_buffer),
    .internal_bus    (internal_bus),
    .chip_select_bar (chip_select_bar),
    .read_bar        (read_bar),
    .write_bar       (write_bar),
    .A0              (a0),
    .ICW_1_flag      (icw1_f),
    .ICW_2_flag      (icw2_f),
    .ICW_3_flag      (icw3_f),
    .ICW_4_flag      (icw4_f),
    .OCW_1_flag      (ocw1_f),
    .OCW_2_flag      (ocw2_f),
    .OCW_3_flag      (ocw3_f),
    .debug_state     (debug_state)
  );

  logic [6:0] dut_flags;
  assign dut_flags = {ocw3_f, ocw2_f, ocw1_f, icw4_f, icw3_f, icw2_f, icw1_f};

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  // Initialisation is modelled as a queue of the A0=1 registers still owed
  // after ICW1; once that queue drains the device is initialised.
  logic [6:0] pending[$];
  bit         initialised;
  logic [6:0] exp_flags;
  logic [7:0] exp_bus;
  logic       m_a0;
  bit         m_prev_wr;

  function automatic logic [6:0] model_decode(input logic a0_v, input logic [7:0] d);
    logic [6:0] f;
    f = F_NONE;
    if (!a0_v && d[4]) begin
      pending.delete();
      pending.push_back(F_ICW2);
      if (!d[1]) pending.push_back(F_ICW3);
      if (d[0])  pending.push_back(F_ICW4);
      initialised = 1'b0;
      f = F_ICW1;
    end else if (pending.size() > 0) begin
      if (a0_v) begin
        f = pending.pop_front();
        if (pending.size() == 0) initialised = 1'b1;
      end
    end else if (initialised) begin
      if (a0_v)      f = F_OCW1;
      else if (d[3]) f = F_OCW3;
      else           f = F_OCW2;
    end
    return f;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit cur;
    if (reset) begin
      exp_flags   = F_NONE;
      exp_bus     = 8'h00;
      m_a0        = 1'b0;
      m_prev_wr   = 1'b0;
      initialised = 1'b0;
      pending.delete();
    end else begin
      cur = !chip_select_bar && !write_bar && read_bar;
      exp_flags = (m_prev_wr && !cur) ? model_decode(m_a0, exp_bus) : F_NONE;
      if (cur) begin
        exp_bus = drv_data;
        m_a0    = a0;
      end
      m_prev_wr = cur;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      vectors++;
      if (dut_flags !== exp_flags || internal_bus !== exp_bus) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t flags got %b want %b, bus got %h want %h",
                 $time, dut_flags, exp_flags, internal_bus, exp_bus);
      end
    end
  end

  // ---------------- literal checks (pin the model) ----------------
  task automatic check_lit(input string name, input logic [6:0] gf, input logic [6:0] wf,
                           input logic [7:0] gb, input logic [7:0] wb);
    vectors++;
    if (gf !== wf || gb !== wb) begin
      miscompares++;
      $display("FAIL %s flags got %b want %b, bus got %h want %h", name, gf, wf, gb, wb);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents one write for one clock edge, releases it, then checks the flag
  // in the cycle after the closing edge and that it is gone one cycle later.
  task automatic do_write(input string name, input logic a0_v, input logic [7:0] d,
                          input logic [6:0] want_f, input logic [7:0] want_bus);
    @(negedge clk);
    chip_select_bar = 1'b0; write_bar = 1'b0; read_bar = 1'b1;
    a0 = a0_v; drv_data = d;
    @(negedge clk);
    write_bar = 1'b1; chip_select_bar = 1'b1;
    @(posedge clk); #1;
    check_lit(name, dut_flags, want_f, internal_bus, want_bus);
    @(posedge clk); #1;
    check_lit({name, "_off"}, dut_flags, F_NONE, internal_bus, want_bus);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
    check_lit("reset_state", dut_flags, F_NONE, internal_bus, 8'h00);

    // Reset asserted in the middle of a write: write is discarded.
    @(negedge clk);
    chip_select_bar = 1'b0; write_bar = 1'b0; a0 = 1'b0; drv_data = 8'h10;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_lit("reset_midwrite", dut_flags, F_NONE, internal_bus, 8'h00);
    @(negedge clk);
    write_bar = 1'b1; chip_select_bar = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(3);
    check_lit("after_reset", dut_flags, F_NONE, internal_bus, 8'h00);
    do_write("a0_1_uninit", 1'b1, 8'h20, F_NONE, 8'h20);

    // Cascade mode, no ICW4.
    do_write("icw1_10", 1'b0, 8'h10, F_ICW1, 8'h10);
    do_write("icw2_08", 1'b1, 8'h08, F_ICW2, 8'h08);
    do_write("icw3_04", 1'b1, 8'h04, F_ICW3, 8'h04);
    do_write("ocw1_ff", 1'b1, 8'hFF, F_OCW1, 8'hFF);

    // Single mode with ICW4: ICW3 skipped.
    do_write("icw1_13", 1'b0, 8'h13, F_ICW1, 8'h13);
    do_write("icw2_20", 1'b1, 8'h20, F_ICW2, 8'h20);
    do_write("icw4_01", 1'b1, 8'h01, F_ICW4, 8'h01);
    do_write("ocw2_20", 1'b0, 8'h20, F_OCW2, 8'h20);
    do_write("ocw3_0b", 1'b0, 8'h0B, F_OCW3, 8'h0B);

    // Write strobe while deselected: ignored.
    @(negedge clk);
    chip_select_bar = 1'b1; write_bar = 1'b0; a0 = 1'b1; drv_data = 8'h55;
    @(negedge clk);
    write_bar = 1'b1;
    idle_cycles(2);
    check_lit("deselected_wr", dut_flags, F_NONE, internal_bus, 8'h0B);

    // Read and write together: not a write.
    @(negedge clk);
    chip_select_bar = 1'b0; write_bar = 1'b0; read_bar = 1'b0; drv_data = 8'hAA;
    @(negedge clk);
    write_bar = 1'b1; read_bar = 1'b1; chip_select_bar = 1'b1;
    idle_cycles(2);
    check_lit("rd_wr_clash", dut_flags, F_NONE, internal_bus, 8'h0B);

    // Plain read: no effect.
    @(negedge clk);
    chip_select_bar = 1'b0; read_bar = 1'b0; a0 = 1'b0; drv_data = 8'h10;
    @(negedge clk);
    read_bar = 1'b1; chip_select_bar = 1'b1;
    idle_cycles(2);
    check_lit("read_only", dut_flags, F_NONE, internal_bus, 8'h0B);

    // ICW1 while waiting for ICW3 restarts the sequence.
    do_write("icw1_re_a", 1'b0, 8'h10, F_ICW1, 8'h10);
    do_write("icw2_re_a", 1'b1, 8'h08, F_ICW2, 8'h08);
    do_write("icw1_in_w3", 1'b0, 8'h10, F_ICW1, 8'h10);
    do_write("icw2_restart", 1'b1, 8'h09, F_ICW2, 8'h09);
    do_write("icw3_restart", 1'b1, 8'h02, F_ICW3, 8'h02);
    do_write("ocw1_restart", 1'b1, 8'h3C, F_OCW1, 8'h3C);

    // Deselect before write_bar rises also ends the write.
    @(negedge clk);
    chip_select_bar = 1'b0; write_bar = 1'b0; a0 = 1'b1; drv_data = 8'hC3;
    @(negedge clk);
    chip_select_bar = 1'b1;
    @(posedge clk); #1;
    check_lit("cs_end_wr", dut_flags, F_OCW1, internal_bus, 8'hC3);
    @(negedge clk);
    write_bar = 1'b1;
    idle_cycles(2);
    check_lit("cs_end_quiet", dut_flags, F_NONE, internal_bus, 8'hC3);

    // Data changes while write_bar is low: last byte (0x08 -> OCW3) wins.
    @(negedge clk);
    chip_select_bar = 1'b0; write_bar = 1'b0; a0 = 1'b0; drv_data = 8'h00;
    @(negedge clk);
    drv_data = 8'h08;
    @(negedge clk);
    write_bar = 1'b1; chip_select_bar = 1'b1;
    @(posedge clk); #1;
    check_lit("last_wins", dut_flags, F_OCW3, internal_bus, 8'h08);
    @(posedge clk); #1;
    check_lit("last_wins_off", dut_flags, F_NONE, internal_bus, 8'h08);

    // Invalid A0=0 non-ICW1 outside READY: no flag.
    do_write("icw1_11", 1'b0, 8'h11, F_ICW1, 8'h11);
    do_write("a0_0_in_w2", 1'b0, 8'h08, F_NONE, 8'h08);
    do_write("icw2_after", 1'b1, 8'h40, F_ICW2, 8'h40);
    do_write("icw3_after", 1'b1, 8'h00, F_ICW3, 8'h00);
    do_write("icw4_after", 1'b1, 8'h01, F_ICW4, 8'h01);

    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
